// File: rtl/spi_slave_top.sv
// SPI slave with a 4-register bus window and byte-wide TX/RX FIFOs.
// The bus has no write strobe: each access returns the register's value from before the access and applies bus_din_i in the same cycle.
module spi_slave_top #(
  parameter logic [31:0] BASE_ADDR = 32'h2002_0000,
  parameter int unsigned FIFO_W    = 3
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        bus_enable_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_din_i,
  output logic [31:0] bus_dout_o,
  output logic        bus_ready_o,
  input  logic        spi_cs_i,
  input  logic        spi_sclk_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

  localparam int unsigned     DEPTH    = 1 << FIFO_W;
  localparam logic [FIFO_W:0] FULL_CNT = (FIFO_W + 1)'(DEPTH);

  state_e state_q, state_d;
  logic        ctrl_en_q, ctrl_cpha_q, ctrl_cpol_q;
  logic        rx_ovr_q, tx_und_q;
  logic [31:0] dout_q;
  logic        ready_q;
  logic [2:0]  cs_sync_q, sclk_sync_q;
  logic [1:0]  mosi_sync_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  rx_sr_q, tx_sr_q;
  logic        miso_q;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [FIFO_W:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;

  // Bus decode
  logic [31:0] offset;
  logic        hit, acc_ctrl, acc_status, acc_rx, acc_tx, flush;
  logic [31:0] rdata;
  logic        unused_din;

  assign offset     = bus_addr_i - BASE_ADDR;
  assign hit        = bus_enable_i && (offset[31:4] == 28'd0) && (offset[1:0] == 2'd0);
  assign acc_ctrl   = hit && (offset[3:2] == 2'd0);
  assign acc_status = hit && (offset[3:2] == 2'd1);
  assign acc_rx     = hit && (offset[3:2] == 2'd2);
  assign acc_tx     = hit && (offset[3:2] == 2'd3);
  assign flush      = acc_ctrl && bus_din_i[1];
  assign unused_din = ^bus_din_i[31:8];

  // FIFO status
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic load_tx, push_rx;
  logic [7:0] tx_head;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign tx_full  = ((tx_wr_q - tx_rd_q) == FULL_CNT);
  assign rx_full  = ((rx_wr_q - rx_rd_q) == FULL_CNT);
  assign tx_push  = acc_tx && !tx_full;
  assign tx_pop   = load_tx && !tx_empty;
  assign rx_push  = push_rx && !rx_full;
  assign rx_pop   = acc_rx && !rx_empty;
  assign tx_head  = tx_empty ? 8'hFF : tx_mem[tx_rd_q[FIFO_W-1:0]];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rdata = '0;
    case (offset[3:2])
      2'd0:    rdata = {28'd0, ctrl_cpol_q, ctrl_cpha_q, 1'b0, ctrl_en_q};
      2'd1:    rdata = {26'd0, rx_ovr_q, tx_und_q, rx_empty, tx_empty, rx_full, tx_full};
      2'd2:    rdata = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_q[FIFO_W-1:0]]};
      default: rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ready_q     <= 1'b0;
      dout_q      <= '0;
      ctrl_en_q   <= 1'b0;
      ctrl_cpha_q <= 1'b0;
      ctrl_cpol_q <= 1'b0;
      rx_ovr_q    <= 1'b0;
      tx_und_q    <= 1'b0;
    end else begin
      ready_q <= hit;
      if (hit) dout_q <= rdata;
      if (acc_ctrl) begin
        ctrl_en_q   <= bus_din_i[0];
        ctrl_cpha_q <= bus_din_i[2];
        ctrl_cpol_q <= bus_din_i[3];
      end
      if (push_rx && rx_full)                 rx_ovr_q <= 1'b1;
      else if (acc_status && bus_din_i[5])    rx_ovr_q <= 1'b0;
      if (load_tx && tx_empty)                tx_und_q <= 1'b1;
      else if (acc_status && bus_din_i[4])    tx_und_q <= 1'b0;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_q[FIFO_W-1:0]] <= bus_din_i[7:0];
    if (rx_push) rx_mem[rx_wr_q[FIFO_W-1:0]] <= rx_sr_q;
  end

  // Flush beats any same-cycle push or pop
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else if (flush) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
    end
  end

  // CS resets to "low" so a CS held low across reset never looks like a new falling edge
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_i};
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
    end
  end

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge;

  assign cs_fall     = !cs_sync_q[1] &&  cs_sync_q[2];
  assign cs_rise     =  cs_sync_q[1] && !cs_sync_q[2];
  assign sclk_rise   =  sclk_sync_q[1] && !sclk_sync_q[2];
  assign sclk_fall   = !sclk_sync_q[1] &&  sclk_sync_q[2];
  assign lead_edge   = ctrl_cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = ctrl_cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = ctrl_cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = ctrl_cpha_q ? lead_edge : trail_edge;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_tx = 1'b0;
    push_rx = 1'b0;
    case (state_q)
      S_IDLE:  if (cs_fall && ctrl_en_q) state_d = S_LOAD;
      S_LOAD: begin
        load_tx = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: if (sample_edge && bit_cnt_q == 3'd7) state_d = S_DONE;
      S_DONE: begin
        push_rx = 1'b1;
        load_tx = 1'b1;
        state_d = S_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
    if (cs_rise) begin
      state_d = S_IDLE;
      load_tx = 1'b0;
      push_rx = 1'b0;
    end
  end

  // With cpha=0 bit 7 is already on the line after a load, so the trailing edge right after a reload must not shift
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '1;
      miso_q    <= 1'b1;
    end else if (cs_rise) begin
      bit_cnt_q <= '0;
    end else if (load_tx) begin
      bit_cnt_q <= '0;
      if (ctrl_cpha_q) begin
        tx_sr_q <= tx_head;
        miso_q  <= 1'b1;
      end else begin
        tx_sr_q <= {tx_head[6:0], 1'b1};
        miso_q  <= tx_head[7];
      end
    end else if (state_q == S_SHIFT) begin
      if (sample_edge) begin
        rx_sr_q   <= {rx_sr_q[6:0], mosi_sync_q[1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (shift_edge && (ctrl_cpha_q || bit_cnt_q != 3'd0)) begin
        miso_q  <= tx_sr_q[7];
        tx_sr_q <= {tx_sr_q[6:0], 1'b1};
      end
    end
  end

  assign spi_miso_o  = (state_q == S_IDLE) ? 1'b1 : miso_q;
  assign bus_dout_o  = dout_q;
  assign bus_ready_o = ready_q;

endmodule

// File: tb/tb_spi_slave_top.sv
// Randomized self-checking bench for spi_slave_top: acts as SPI master and bus host,
// comparing against a queue-based model of the register/FIFO behaviour.
`timescale 1ns/1ps
module tb_spi_slave_top;

  localparam logic [31:0] BASE   = 32'h2002_0000;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_RX   = BASE + 32'h8;
  localparam logic [31:0] A_TX   = BASE + 32'hC;
  localparam int          HALF   = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bus_enable = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_din = '0;
  logic [31:0] bus_dout;
  logic        bus_ready;
  logic        cs = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;

  spi_slave_top #(.BASE_ADDR(BASE), .FIFO_W(3)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .bus_enable_i(bus_enable), .bus_addr_i(bus_addr), .bus_din_i(bus_din),
    .bus_dout_o(bus_dout), .bus_ready_o(bus_ready),
    .spi_cs_i(cs), .spi_sclk_i(sclk), .spi_mosi_i(mosi), .spi_miso_o(miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic m_en = 0, m_cpha = 0, m_cpol = 0, m_ovr = 0, m_und = 0;
  logic [7:0] pat [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {26'd0, m_ovr, m_und, rx_q.size() == 0, tx_q.size() == 0,
            rx_q.size() == 8, tx_q.size() == 8};
  endfunction

  task automatic m_reset();
    tx_q.delete(); rx_q.delete();
    m_en = 0; m_cpha = 0; m_cpol = 0; m_ovr = 0; m_und = 0;
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] din, output logic [31:0] dout);
    @(posedge clk); #1;
    bus_enable = 1'b1; bus_addr = addr; bus_din = din;
    @(posedge clk); #1;
    bus_enable = 1'b0;
    check("ready", {31'd0, bus_ready}, 32'd1);
    dout = bus_dout;
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    logic [31:0] d;
    bus(A_CTRL, v, d);
    check("ctrl_rd", d, {28'd0, m_cpol, m_cpha, 1'b0, m_en});
    m_en = v[0]; m_cpha = v[2]; m_cpol = v[3];
    if (v[1]) begin tx_q.delete(); rx_q.delete(); end
  endtask

  task automatic rd_status(input logic [31:0] w1c);
    logic [31:0] d;
    bus(A_STAT, w1c, d);
    check("status", d, m_status());
    if (w1c[5]) m_ovr = 0;
    if (w1c[4]) m_und = 0;
  endtask

  task automatic rd_rx();
    logic [31:0] d;
    bus(A_RX, 32'd0, d);
    check("rxdata", d, (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'd0);
  endtask

  task automatic wr_tx(input logic [7:0] b);
    logic [31:0] d;
    bus(A_TX, {24'hABCDEF, b}, d);
    if (tx_q.size() < 8) tx_q.push_back(b);
  endtask

  task automatic hw();
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  // Next byte the slave transmits: TX head, or all-ones when the FIFO is empty
  task automatic m_load(output logic [7:0] b);
    if (tx_q.size() > 0) b = tx_q.pop_front();
    else begin b = 8'hFF; m_und = 1; end
  endtask

  // Master transfer of nbytes full bytes from pat[], then an optional partial byte of tail bits
  task automatic spi_run(input int nbytes, input int tail);
    logic [7:0] rcv [16];
    logic [7:0] cur;
    int total, nb;
    total = nbytes + ((tail > 0) ? 1 : 0);
    sclk = m_cpol; hw();
    cs = 1'b0; hw(); hw();
    for (int b = 0; b < total; b++) begin
      nb = (b < nbytes) ? 8 : tail;
      rcv[b] = 8'h00;
      for (int i = 0; i < nb; i++) begin
        if (!m_cpha) begin
          mosi = pat[b][7-i]; hw();
          rcv[b][7-i] = miso;
          sclk = ~m_cpol; hw();
          sclk = m_cpol;
        end else begin
          sclk = ~m_cpol; mosi = pat[b][7-i]; hw();
          rcv[b][7-i] = miso;
          sclk = m_cpol; hw();
        end
      end
    end
    hw(); cs = 1'b1; hw(); hw();
    check("miso_idle", {31'd0, miso}, 32'd1);
    if (!m_en) begin
      for (int b = 0; b < nbytes; b++) check("miso_dis", {24'd0, rcv[b]}, 32'h0000_00FF);
    end else begin
      m_load(cur);
      for (int b = 0; b < nbytes; b++) begin
        check("miso", {24'd0, rcv[b]}, {24'd0, cur});
        if (rx_q.size() < 8) rx_q.push_back(pat[b]);
        else m_ovr = 1;
        m_load(cur);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  got;
    int mode;

    // Reset values while rstn is low
    repeat (3) @(posedge clk); #1;
    check("rst_dout", bus_dout, 32'd0);
    check("rst_ready", {31'd0, bus_ready}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd1);
    rstn = 1'b1;
    repeat (3) @(posedge clk); #1;
    rd_status(32'd0);
    wr_ctrl(32'd0);

    // Undecoded address: no ready in the following cycle
    @(posedge clk); #1;
    bus_enable = 1'b1; bus_addr = BASE + 32'h10; bus_din = 32'd0;
    @(posedge clk); #1;
    bus_enable = 1'b0;
    check("bad_addr_ready", {31'd0, bus_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_one_cycle", {31'd0, bus_ready}, 32'd0);

    // Mode 0: send A5, receive 3C
    wr_ctrl(32'h1);
    wr_tx(8'hA5);
    pat[0] = 8'h3C;
    spi_run(1, 0);
    rd_rx();
    rd_status(32'h30);

    // Mode 3, three bytes with TX empty
    wr_ctrl(32'hD);
    for (int i = 0; i < 3; i++) pat[i] = 8'($urandom);
    spi_run(3, 0);
    rd_status(32'd0);
    for (int i = 0; i < 3; i++) rd_rx();

    // RX overrun: eight bytes fill, ninth dropped
    wr_ctrl(32'h1);
    for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
    spi_run(8, 0);
    pat[0] = 8'($urandom);
    spi_run(1, 0);
    rd_status(32'd0);
    rd_status(32'h20);
    rd_status(32'd0);
    for (int i = 0; i < 8; i++) rd_rx();

    // Aborted byte after 4 bits, then a clean byte
    pat[0] = 8'h96;
    spi_run(0, 4);
    rd_status(32'd0);
    pat[0] = 8'h5A;
    spi_run(1, 0);
    rd_rx();

    // TX overflow, then flush both FIFOs
    for (int i = 0; i < 9; i++) wr_tx(8'(i + 8'h40));
    rd_status(32'd0);
    wr_ctrl(32'h3);
    rd_status(32'd0);
    wr_ctrl(32'h1);

    // Disabled engine ignores SPI traffic
    wr_tx(8'h11);
    wr_ctrl(32'h0);
    pat[0] = 8'hFF;
    spi_run(1, 0);
    rd_status(32'd0);
    rd_rx();
    wr_ctrl(32'h3);

    // Reset mid-transfer with CS held low: no transfer until a fresh CS falling edge
    wr_ctrl(32'h1);
    sclk = 1'b0; cs = 1'b0; hw(); hw();
    sclk = 1'b1; hw(); sclk = 1'b0; hw();
    rstn = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_mid_miso", {31'd0, miso}, 32'd1);
    check("rst_mid_dout", bus_dout, 32'd0);
    rstn = 1'b1;
    m_reset();
    wr_ctrl(32'h1);
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mosi = 1'($urandom); hw();
      got[7-i] = miso;
      sclk = 1'b1; hw(); sclk = 1'b0;
    end
    check("rst_mid_noxfer", {24'd0, got}, 32'h0000_00FF);
    hw(); cs = 1'b1; hw(); hw();
    rd_status(32'd0);

    // Randomized traffic across all modes
    for (int it = 0; it < 24; it++) begin
      mode = int'($urandom_range(0, 3));
      wr_ctrl({28'd0, mode[1], mode[0], 1'b0, 1'b1});
      repeat ($urandom_range(0, 3)) wr_tx(8'($urandom));
      for (int i = 0; i < 4; i++) pat[i] = 8'($urandom);
      spi_run(int'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
      rd_status({26'd0, 1'($urandom), 1'($urandom), 4'd0});
      repeat ($urandom_range(0, 4)) rd_rx();
      if (rx_q.size() > 5) wr_ctrl({28'd0, mode[1], mode[0], 2'b11});
    end
    bus(A_RX, 32'd0, d);
    check("rx_final", d, (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_top.md
SPI_SLAVE_TOP -- requirements
Module: spi_slave_top

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h2002_0000: base of the 4-register window.
REQ-002 SHALL have parameter FIFO_W, default 3: log2 depth of each byte FIFO (8 entries).
REQ-003 SHALL have port clk_i  input  1  system clock.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port bus_enable_i  input  1  bus access strobe, one cycle.
REQ-006 SHALL have port bus_addr_i  input  32  byte address.
REQ-007 SHALL have port bus_din_i  input  32  write data.
REQ-008 SHALL have port bus_dout_o  output  32  registered read data.
REQ-009 SHALL have port bus_ready_o  output  1  one-cycle access acknowledge.
REQ-010 SHALL have port spi_cs_i  input  1  chip select from master, active-low.
REQ-011 SHALL have port spi_sclk_i  input  1  serial clock from master.
REQ-012 SHALL have port spi_mosi_i  input  1  serial data in.
REQ-013 SHALL have port spi_miso_o  output  1  serial data out.

Function
REQ-014 SHALL decode: BASE+0 CTRL (RW: [0] enable, [1] flush, [2] cpha, [3] cpol); BASE+4 STATUS (R; W1C); BASE+8 RXDATA (R, pop); BASE+C TXDATA (W, push [7:0]).
REQ-015 SHALL assert bus_ready_o for exactly one cycle, the cycle after bus_enable_i with a decoded address; undecoded addresses get no ready.
REQ-016 SHALL return STATUS = {26'b0, rx_overrun, tx_underrun, rx_empty, tx_empty, rx_full, tx_full}; write 1 to bit 5/4 clears that sticky flag.
REQ-017 SHALL return {24'b0, rx head} on RXDATA read and pop; if RX empty, return 0, no pop.
REQ-018 SHALL drop TXDATA writes while TX FIFO full, pointers unchanged.
REQ-019 SHALL, on CTRL write with [1]=1, empty both FIFOs in that cycle; flush bit self-clears and reads 0.
REQ-020 SHALL pass spi_cs_i, spi_sclk_i, spi_mosi_i through 2-FF synchronizers; edges detected on synchronized sclk; clk_i >= 8x sclk required.
REQ-021 SHALL define leading edge = sclk leaving CPOL level; cpha=0: sample on leading, shift on trailing; cpha=1: shift on leading, sample on trailing; MSB first.
REQ-022 SHALL implement FSM S_IDLE, S_LOAD, S_SHIFT, S_DONE.
REQ-023 S_IDLE: miso_o=1; on synced CS falling and enable=1 -> S_LOAD; enable=0 ignores all SPI activity.
REQ-024 S_LOAD (1 cycle): pop TX byte into shift register; if TX empty load 8'hFF and set tx_underrun; cpha=0 drives bit7 on miso_o immediately; -> S_SHIFT, bit counter=0.
REQ-025 S_SHIFT: each sample edge shifts mosi into rx shift register and increments counter; after 8th sample -> S_DONE.
REQ-026 S_DONE (1 cycle): push rx byte; if RX full drop byte, set rx_overrun; reload TX as S_LOAD; -> S_SHIFT.
REQ-027 SHALL, on synced CS rising in any state, discard partial byte, clear counter, go S_IDLE, miso_o=1 next cycle.
REQ-028 SHALL allow simultaneous push and pop on one FIFO in one cycle; count unchanged, full/empty correct.
REQ-029 SHALL give engine push priority over flush only never: flush wins over any same-cycle push/pop.

Reset
REQ-030 SHALL, while rstn_i=0, hold: bus_dout_o=0, bus_ready_o=0, spi_miso_o=1, CTRL=0, FIFOs empty, sticky flags 0, FSM S_IDLE.
REQ-031 SHALL treat reset mid-transfer identically; first post-reset transfer starts only on a new CS falling edge.

Verification
REQ-032 Mode 0: TXDATA=8'hA5, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; RXDATA reads 32'h0000_003C.
REQ-033 Mode 3, 3 bytes back-to-back with TX empty -> miso all 1s, tx_underrun=1, RX holds 3 bytes in order.
REQ-034 Fill RX with 8 bytes, send 9th -> rx_full=1, rx_overrun=1, 9th dropped; W1C 32'h20 to STATUS clears overrun.
REQ-035 CS raised after 4 bits -> no RX push, next transfer receives full byte correctly.
REQ-036 9 TXDATA writes -> 9th dropped, tx_full=1; CTRL write 32'h3 -> tx_empty=1, rx_empty=1.
REQ-037 enable=0, master clocks 8'hFF -> miso stays 1, no FIFO change; RXDATA on empty returns 0.
